// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  // Arbiter FSM: IDLE with no owner, GRANT while an owner holds the resource.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index increment wrapping at n, so non-power-of-2 requester counts stay in range.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set candidate at or above ptr, wrapping to 0.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 8,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  logic [NUM_REQ-1:0] rot_c;
  logic [IDW-1:0]     off_c;
  logic [IDW:0]       sum_c;

  // Rotate candidates so ptr lands at bit 0; doubling the vector provides the wrap.
  assign rot_c = NUM_REQ'({cand, cand} >> ptr);

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  always_comb begin
    found = 1'b0;
    off_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot_c[i] && !found) begin
        found = 1'b1;
        off_c = IDW'(i);
      end
    end
  end

  // Map the offset back to an absolute index; ptr < NUM_REQ keeps the sum below 2*NUM_REQ.
  assign sum_c = {1'b0, ptr} + {1'b0, off_c};
  assign idx   = (sum_c >= (IDW+1)'(NUM_REQ)) ? IDW'(sum_c - (IDW+1)'(NUM_REQ))
                                              : IDW'(sum_c);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a bounded per-owner hold.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 8,
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_valid_o
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  arb_state_e         state_q;
  logic [IDW-1:0]     own_q;
  logic [IDW-1:0]     ptr_q;
  logic [CW-1:0]      cnt_q;

  logic [NUM_REQ-1:0] own_mask_c;
  logic               own_req_c;
  logic               all_found_c;
  logic [IDW-1:0]     all_idx_c;
  logic               oth_found_c;
  logic [IDW-1:0]     oth_idx_c;

  logic               take_c;
  logic               drop_c;
  logic               reload_c;
  logic               inc_c;
  logic [IDW-1:0]     win_c;

  assign own_mask_c = NUM_REQ'(1) << own_q;
  assign own_req_c  = |(req_i & own_mask_c);

  // Candidate winner among all requesters (new grant or release handover).
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_all (
    .cand  (req_i),
    .ptr   (ptr_q),
    .found (all_found_c),
    .idx   (all_idx_c)
  );

  // Candidate winner excluding the current owner (pre-emption at the hold limit).
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_oth (
    .cand  (req_i & ~own_mask_c),
    .ptr   (ptr_q),
    .found (oth_found_c),
    .idx   (oth_idx_c)
  );

  // Decide this cycle's action: new grant, drop to idle, hold reload or hold count.
  always_comb begin
    take_c   = 1'b0;
    drop_c   = 1'b0;
    reload_c = 1'b0;
    inc_c    = 1'b0;
    win_c    = all_idx_c;
    case (state_q)
      IDLE: begin
        take_c = all_found_c;
      end
      GRANT: begin
        if (!own_req_c) begin
          if (all_found_c) take_c = 1'b1;
          else             drop_c = 1'b1;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          if (oth_found_c) begin
            take_c = 1'b1;
            win_c  = oth_idx_c;
          end else begin
            reload_c = 1'b1;
          end
        end else begin
          inc_c = 1'b1;
        end
      end
      default: begin
        drop_c = 1'b1;
      end
    endcase
  end

  // FSM state, owner, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      own_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
    end else if (take_c) begin
      state_q     <= GRANT;
      own_q       <= win_c;
      cnt_q       <= CW'(1);
      ptr_q       <= IDW'(wrap_inc(32'(win_c), NUM_REQ));
      gnt_o       <= NUM_REQ'(1) << win_c;
      gnt_id_o    <= win_c;
      gnt_valid_o <= 1'b1;
    end else if (drop_c) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
    end else if (reload_c) begin
      cnt_q <= CW'(1);
    end else if (inc_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: an 8-requester and a 5-requester instance against a reference model.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req8;
  logic [4:0] req5;
  logic [7:0] gnt8;
  logic [2:0] id8;
  logic       v8;
  logic [4:0] gnt5;
  logic [2:0] id5;
  logic       v5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(8), .MAX_HOLD(4)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req8),
    .gnt_o(gnt8), .gnt_id_o(id8), .gnt_valid_o(v8)
  );

  rr_arbiter #(.NUM_REQ(5), .MAX_HOLD(2)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req5),
    .gnt_o(gnt5), .gnt_id_o(id5), .gnt_valid_o(v5)
  );

  typedef struct {
    logic [7:0] g8;
    logic [2:0] i8;
    logic       v8;
    logic [4:0] g5;
    logic [2:0] i5;
    logic       v5;
  } exp_t;

  exp_t q[$];

  // Reference model: who owns the resource, how long it has held it, where the search starts.
  bit m_idle [2];
  int m_own  [2];
  int m_ptr  [2];
  int m_held [2];

  function automatic int m_n(input int u);
    return (u == 0) ? 8 : 5;
  endfunction

  function automatic int m_limit(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idle[u] = 1'b1;
      m_own[u]  = 0;
      m_ptr[u]  = 0;
      m_held[u] = 0;
    end
  endfunction

  // Walk the requesters starting at the pointer; optionally skip the current owner.
  function automatic int model_pick(input int u, input logic [7:0] req, input bit skip_own);
    for (int k = 0; k < m_n(u); k++) begin
      int j;
      j = (m_ptr[u] + k) % m_n(u);
      if (req[j] && !(skip_own && j == m_own[u])) return j;
    end
    return -1;
  endfunction

  function automatic void model_give(input int u, input int w);
    m_idle[u] = 1'b0;
    m_own[u]  = w;
    m_held[u] = 1;
    m_ptr[u]  = (w + 1) % m_n(u);
  endfunction

  // One clock of arbitration for instance u given the request vector it samples.
  function automatic void model_step(input int u, input logic [7:0] req);
    int w;
    if (m_idle[u]) begin
      w = model_pick(u, req, 1'b0);
      if (w >= 0) model_give(u, w);
    end else if (!req[m_own[u]]) begin
      w = model_pick(u, req, 1'b0);
      if (w >= 0) model_give(u, w);
      else        m_idle[u] = 1'b1;
    end else if (m_held[u] == m_limit(u)) begin
      w = model_pick(u, req, 1'b1);
      if (w >= 0) model_give(u, w);
      else        m_held[u] = 1;
    end else begin
      m_held[u]++;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.v8 = !m_idle[0];
    e.i8 = m_idle[0] ? 3'd0 : 3'(m_own[0]);
    e.g8 = m_idle[0] ? 8'h00 : (8'h01 << m_own[0]);
    e.v5 = !m_idle[1];
    e.i5 = m_idle[1] ? 3'd0 : 3'(m_own[1]);
    e.g5 = m_idle[1] ? 5'h00 : (5'h01 << m_own[1]);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests on the falling edge and queue what the DUTs must show next.
  task automatic drive(input logic [7:0] r8, input logic [4:0] r5);
    @(negedge clk);
    req8 = r8;
    req5 = r5;
    model_step(0, r8);
    model_step(1, {3'b000, r5});
    q.push_back(model_out());
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req8  = 8'h00;
    req5  = 5'h00;
    model_step(0, 8'h00);
    model_step(1, 8'h00);
    q.push_back(model_out());
  endtask

  // Monitor: pop expectations after each rising edge, plus per-cycle one-hot checks.
  always @(posedge clk) begin
    exp_t e;
    #1;
    chk("onehot8", 32'($onehot0(gnt8)), 32'd1);
    chk("onehot5", 32'($onehot0(gnt5)), 32'd1);
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("gnt8",   32'(gnt8), 32'(e.g8));
      chk("id8",    32'(id8),  32'(e.i8));
      chk("valid8", 32'(v8),   32'(e.v8));
      chk("gnt5",   32'(gnt5), 32'(e.g5));
      chk("id5",    32'(id5),  32'(e.i5));
      chk("valid5", 32'(v5),   32'(e.v5));
    end
  end

  initial begin
    logic [7:0] r8;
    logic [4:0] r5;
    model_reset();
    rst_n = 1'b0;
    req8  = 8'hFF;
    req5  = 5'h1F;
    repeat (3) @(negedge clk);
    chk("rst_gnt8",   32'(gnt8), 32'd0);
    chk("rst_valid8", 32'(v8),   32'd0);
    chk("rst_id8",    32'(id8),  32'd0);
    chk("rst_gnt5",   32'(gnt5), 32'd0);
    chk("rst_valid5", 32'(v5),   32'd0);
    release_reset();
    repeat (2) drive(8'h00, 5'h00);

    // Single requester 3, held then released.
    repeat (6) drive(8'h08, 5'h00);
    repeat (2) drive(8'h00, 5'h00);

    // Full contention: rotation through every requester.
    repeat (34) drive(8'hFF, 5'h1F);
    repeat (2) drive(8'h00, 5'h00);

    // Release handover between requesters 2 and 5.
    repeat (2) drive(8'h24, 5'h00);
    repeat (3) drive(8'h20, 5'h00);
    repeat (2) drive(8'h00, 5'h00);

    // Sole requester held long past the hold limit; 5-wide instance wraps 4 -> 0.
    repeat (20) drive(8'h01, 5'b10001);
    repeat (2) drive(8'h00, 5'h00);
    repeat (12) drive(8'h00, 5'b10000);
    repeat (12) drive(8'h00, 5'b10001);

    // Random traffic with some persistence so holds and pre-emptions occur.
    r8 = 8'h00;
    r5 = 5'h00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) r8 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r5 = 5'($urandom);
      drive(r8, r5);
    end

    // Asynchronous reset in the middle of a grant.
    repeat (6) drive(8'hFF, 5'h1F);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt8",   32'(gnt8), 32'd0);
    chk("async_valid8", 32'(v8),   32'd0);
    chk("async_gnt5",   32'(gnt5), 32'd0);
    chk("async_valid5", 32'(v5),   32'd0);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
    for (int i = 0; i < 40; i++) drive(8'($urandom), 5'($urandom));

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
